pl_stage_buf: RTL and testbench
===============================

PL_STAGE_BUF -- requirements
Module: pl_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 96, payload width (Instr+PC+PCPlus4 packed).
REQ-002 SHALL have parameter BUBBLE, default all-zero WIDTH bits, payload value driven and stored when no valid entry exists.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single register with combinational in_ready.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port clr  in  1  synchronous flush; discards all buffered entries.
REQ-007 SHALL have port in_valid  in  1  upstream (fetch) payload valid.
REQ-008 SHALL have port in_ready  out  1  buffer accepts payload this cycle.
REQ-009 SHALL have port in_data  in  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  out  1  out_data holds a valid entry.
REQ-011 SHALL have port out_ready  in  1  downstream (decode) consumes this cycle.
REQ-012 SHALL have port out_data  out  WIDTH  oldest buffered payload, BUBBLE when out_valid=0.
REQ-013 SHALL have port occ  out  2  current entry count, 0..2.

Function
REQ-014 Transfer SHALL occur on a side only when valid and ready are both 1 at a rising edge; no payload is duplicated or lost except on clr/rst.
REQ-015 Latency SHALL be 1 cycle from input acceptance to out_valid=1 with that payload when the buffer was empty; sustained throughput SHALL be 1 payload/cycle while out_ready=1.
REQ-016 SKID=1 SHALL use states EMPTY (occ=0), ONE (main valid, occ=1), TWO (main+skid valid, occ=2).
REQ-017 EMPTY: in accepted -> ONE, main<=in_data; else stay.
REQ-018 ONE: in and out fire -> ONE, main<=in_data; in only -> TWO, skid<=in_data; out only -> EMPTY, main<=BUBBLE; neither -> stay.
REQ-019 TWO: out fires -> ONE, main<=skid, skid<=BUBBLE; else stay; no input accepted in TWO.
REQ-020 SKID=1: in_ready SHALL be a register, 1 exactly when state is EMPTY or ONE; it SHALL NOT depend combinationally on out_ready.
REQ-021 SKID=0: single entry; in_ready = !out_valid | out_ready combinationally; occ SHALL never exceed 1; skid register SHALL not be instantiated.
REQ-022 out_valid SHALL be 1 exactly when occ>=1; out_data SHALL be main register (BUBBLE when invalid).
REQ-023 clr=1 SHALL force state EMPTY, all data registers to BUBBLE, occ=0 at the next edge; any input presented during clr SHALL be dropped and any output handshake that cycle SHALL still count as consumed.
REQ-024 clr SHALL not change in_ready/out_valid combinationally in the clr cycle; effect is visible from the next cycle.
REQ-025 Payload SHALL pass unmodified bit-for-bit for all WIDTH>=1.

Reset
REQ-026 rst=1 SHALL, at the next edge, set state EMPTY, occ=0, out_valid=0, out_data=BUBBLE, skid=BUBBLE, in_ready=1 (both modes).
REQ-027 rst SHALL take priority over clr and over any handshake in the same cycle.
REQ-028 rst asserted mid-operation (occ=2) SHALL discard both entries with no output transfer afterwards.

Structure
REQ-029 State encoding (EMPTY/ONE/TWO) and a default BUBBLE/NOP constant SHALL live in shared package pl_pkg.
REQ-030 Block SHALL be flat; no sub-module; SKID selects logic via generate.

Verification
REQ-031 Reset then in_valid=1, in_data=0x...0001, out_ready=1 -> out_valid=1, out_data=0x...0001 one cycle later, occ=1.
REQ-032 SKID=1, out_ready=0, push A,B -> occ=2, in_ready=0 next cycle, C held upstream; release out_ready -> A, B, C emerge in order on consecutive cycles.
REQ-033 Streaming 100 incrementing words with out_ready=1 -> 100 outputs, one per cycle, no gaps after the first, in order.
REQ-034 occ=2, assert clr with in_valid=1 (data D) -> next cycle occ=0, out_valid=0, out_data=BUBBLE; D never appears.
REQ-035 rst and clr together with occ=2 -> reset state per REQ-026.
REQ-036 SKID=0, random in_valid/out_ready 10k cycles -> scoreboard matches, occ<=1, in_ready equals !out_valid|out_ready every cycle.

Source files
------------

// File: rtl/pl_pkg.sv
// rtl/pl_pkg.sv - shared pipeline-stage buffer state encoding and bubble constant
package pl_pkg;

  // Payload width for a fetch->decode bundle: Instr(32) + PC(32) + PCPlus4(32).
  localparam int PL_WIDTH_DEFAULT = 96;

  // Value carried by empty slots; all-zero so an invalid slot decodes as a bubble.
  localparam logic [PL_WIDTH_DEFAULT-1:0] PL_BUBBLE = '0;

  // Buffer fill state; the encoding value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pl_state_e;

  // Entry count reported on occ for a given fill state.
  function automatic logic [1:0] occ_of_state(input pl_state_e st);
    case (st)
      ST_ONE:  occ_of_state = 2'd1;
      ST_TWO:  occ_of_state = 2'd2;
      default: occ_of_state = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pl_stage_buf.sv
// rtl/pl_stage_buf.sv - fetch/decode pipeline stage buffer, skid or single-register variant
module pl_stage_buf
  import pl_pkg::*;
#(
  parameter int               WIDTH  = PL_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PL_BUBBLE),
  parameter int               SKID   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  if (SKID != 0) begin : g_skid

    pl_state_e        r_state;
    pl_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // in_ready comes straight from a flop, so upstream never sees out_ready combinationally
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & out_ready;

    // State and data registers; reset and flush both empty the buffer, reset taking precedence
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= ST_EMPTY;
        r_main     <= BUBBLE;
        r_skid     <= BUBBLE;
        r_in_ready <= 1'b1;
      end else if (clr) begin
        r_state    <= ST_EMPTY;
        r_main     <= BUBBLE;
        r_skid     <= BUBBLE;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_state_nxt;
        r_main     <= w_main_nxt;
        r_skid     <= w_skid_nxt;
        r_in_ready <= (w_state_nxt != ST_TWO);
      end
    end

    // Next fill state from the two handshakes
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) w_state_nxt = ST_ONE;
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = ST_TWO;
          else if (!w_in_fire && w_out_fire) w_state_nxt = ST_EMPTY;
          else                               w_state_nxt = ST_ONE;
        end
        ST_TWO: begin
          if (w_out_fire) w_state_nxt = ST_ONE;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end

    // Next data contents: main always holds the oldest entry, skid the younger one
    always_comb begin
      w_main_nxt = r_main;
      w_skid_nxt = r_skid;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) w_main_nxt = in_data;
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt = in_data;
          end else if (w_out_fire) begin
            w_main_nxt = BUBBLE;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_main_nxt = r_skid;
            w_skid_nxt = BUBBLE;
          end
        end
        default: begin
          w_main_nxt = BUBBLE;
          w_skid_nxt = BUBBLE;
        end
      endcase
    end

    // Port outputs decoded from registered state only
    always_comb begin
      in_ready  = r_in_ready;
      out_valid = (r_state != ST_EMPTY);
      out_data  = r_main;
      occ       = occ_of_state(r_state);
    end

  end else begin : g_single

    pl_state_e        r_state;
    pl_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_nxt;
    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // The single slot may be refilled in the same cycle it drains, hence out_ready in the path
    assign w_out_valid = (r_state == ST_ONE);
    assign w_in_ready  = !w_out_valid | out_ready;
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // State and data registers; reset and flush both empty the slot, reset taking precedence
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_EMPTY;
        r_main  <= BUBBLE;
      end else if (clr) begin
        r_state <= ST_EMPTY;
        r_main  <= BUBBLE;
      end else begin
        r_state <= w_state_nxt;
        r_main  <= w_main_nxt;
      end
    end

    // Next fill state: an accepted input always leaves the slot full
    always_comb begin
      w_state_nxt = r_state;
      if (w_in_fire)       w_state_nxt = ST_ONE;
      else if (w_out_fire) w_state_nxt = ST_EMPTY;
      else if (r_state == ST_TWO) w_state_nxt = ST_EMPTY;
    end

    // Next slot contents; a drained slot returns to the bubble value
    always_comb begin
      w_main_nxt = r_main;
      if (w_in_fire)       w_main_nxt = in_data;
      else if (w_out_fire) w_main_nxt = BUBBLE;
    end

    // Port outputs
    always_comb begin
      in_ready  = w_in_ready;
      out_valid = w_out_valid;
      out_data  = r_main;
      occ       = occ_of_state(r_state);
    end

  end

endmodule

// File: tb/tb_pl_stage_buf.sv
// tb/tb_pl_stage_buf.sv - self-checking bench for pl_stage_buf, skid and single-register variants
module tb_pl_stage_buf;

  localparam int W = 96;
  localparam logic [W-1:0] BUB1 = '0;
  localparam logic [W-1:0] BUB0 = 96'h13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clr, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         s1_in_ready, s1_out_valid;
  logic [W-1:0] s1_out_data;
  logic [1:0]   s1_occ;
  logic         s0_in_ready, s0_out_valid;
  logic [W-1:0] s0_out_data;
  logic [1:0]   s0_occ;

  int checks   = 0;
  int failures = 0;

  // Reference contents of each buffer, oldest first
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  pl_stage_buf #(.WIDTH(W), .BUBBLE(BUB1), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(s1_in_ready), .in_data(in_data),
    .out_valid(s1_out_valid), .out_ready(out_ready), .out_data(s1_out_data),
    .occ(s1_occ)
  );

  pl_stage_buf #(.WIDTH(W), .BUBBLE(BUB0), .SKID(0)) u_single (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
    .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
    .occ(s0_occ)
  );

  function automatic logic [W-1:0] head1();
    if (q1.size() > 0) return q1[0];
    return BUB1;
  endfunction

  function automatic logic [W-1:0] head0();
    if (q0.size() > 0) return q0[0];
    return BUB0;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic c, input logic r);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    rst       = r;
    #1;
  endtask

  // Advance one clock and update the reference queues from the handshakes of this cycle
  task automatic tick();
    bit           f_in1, f_out1, f_in0, f_out0, kill;
    logic [W-1:0] d;
    f_in1  = in_valid && (q1.size() < 2);
    f_out1 = out_ready && (q1.size() > 0);
    f_in0  = in_valid && ((q0.size() == 0) || out_ready);
    f_out0 = out_ready && (q0.size() > 0);
    kill   = rst || clr;
    d      = in_data;
    @(posedge clk);
    if (kill) begin
      q1.delete();
      q0.delete();
    end else begin
      if (f_out1) void'(q1.pop_front());
      if (f_in1)  q1.push_back(d);
      if (f_out0) void'(q0.pop_front());
      if (f_in0)  q0.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, rand_word(), 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (s1_occ !== 2'd0) begin failures++; $display("FAIL reset_occ1 got=%0d exp=0", s1_occ); end
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%0b exp=0", s1_out_valid); end
    checks++; if (s1_out_data !== BUB1) begin failures++; $display("FAIL reset_data1 got=%0h exp=%0h", s1_out_data, BUB1); end
    checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL reset_inrdy1 got=%0b exp=1", s1_in_ready); end
    checks++; if (s0_occ !== 2'd0) begin failures++; $display("FAIL reset_occ0 got=%0d exp=0", s0_occ); end
    checks++; if (s0_out_data !== BUB0) begin failures++; $display("FAIL reset_data0 got=%0h exp=%0h", s0_out_data, BUB0); end
    checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL reset_inrdy0 got=%0b exp=1", s0_in_ready); end
  endtask

  task automatic test_first_word();
    logic [W-1:0] one;
    one = 96'h1;
    drive(1'b1, one, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (s1_out_valid !== 1'b1) begin failures++; $display("FAIL first_valid1 got=%0b exp=1", s1_out_valid); end
    checks++; if (s1_out_data !== one) begin failures++; $display("FAIL first_data1 got=%0h exp=%0h", s1_out_data, one); end
    checks++; if (s1_occ !== 2'd1) begin failures++; $display("FAIL first_occ1 got=%0d exp=1", s1_occ); end
    checks++; if (s0_out_data !== one) begin failures++; $display("FAIL first_data0 got=%0h exp=%0h", s0_out_data, one); end
    checks++; if (s0_occ !== 2'd1) begin failures++; $display("FAIL first_occ0 got=%0d exp=1", s0_occ); end
    tick();
    drain();
  endtask

  task automatic test_skid_fill();
    logic [W-1:0] a, b, c;
    a = rand_word(); b = rand_word(); c = rand_word();
    drive(1'b1, a, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, c, 1'b0, 1'b0, 1'b0);
    checks++; if (s1_occ !== 2'd2) begin failures++; $display("FAIL fill_occ2 got=%0d exp=2", s1_occ); end
    checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("FAIL fill_inrdy got=%0b exp=0", s1_in_ready); end
    checks++; if (s0_occ !== 2'd1) begin failures++; $display("FAIL fill_occ0 got=%0d exp=1", s0_occ); end
    tick();
    drive(1'b1, c, 1'b1, 1'b0, 1'b0);
    checks++; if (s1_out_data !== a || s1_out_valid !== 1'b1) begin failures++; $display("FAIL order_a got=%0h exp=%0h", s1_out_data, a); end
    tick();
    drive(1'b1, c, 1'b1, 1'b0, 1'b0);
    checks++; if (s1_out_data !== b || s1_out_valid !== 1'b1) begin failures++; $display("FAIL order_b got=%0h exp=%0h", s1_out_data, b); end
    checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL reopen_inrdy got=%0b exp=1", s1_in_ready); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (s1_out_data !== c || s1_out_valid !== 1'b1) begin failures++; $display("FAIL order_c got=%0h exp=%0h", s1_out_data, c); end
    tick();
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%0b exp=0", s1_out_valid); end
    drain();
  endtask

  task automatic test_stream();
    int n1, n0, gap1, gap0;
    logic [W-1:0] base;
    n1 = 0; n0 = 0; gap1 = 0; gap0 = 0;
    base = rand_word();
    for (int i = 0; i < 110; i++) begin
      drive(i < 100, base + W'(i), 1'b1, 1'b0, 1'b0);
      if (s1_out_valid) begin
        checks++;
        if (s1_out_data !== base + W'(n1)) begin failures++; $display("FAIL stream_data1 got=%0h exp=%0h", s1_out_data, base + W'(n1)); end
        n1++;
      end else if (n1 > 0 && n1 < 100) gap1++;
      if (s0_out_valid) begin
        checks++;
        if (s0_out_data !== base + W'(n0)) begin failures++; $display("FAIL stream_data0 got=%0h exp=%0h", s0_out_data, base + W'(n0)); end
        n0++;
      end else if (n0 > 0 && n0 < 100) gap0++;
      tick();
    end
    checks++; if (n1 != 100) begin failures++; $display("FAIL stream_count1 got=%0d exp=100", n1); end
    checks++; if (gap1 != 0) begin failures++; $display("FAIL stream_gaps1 got=%0d exp=0", gap1); end
    checks++; if (n0 != 100) begin failures++; $display("FAIL stream_count0 got=%0d exp=100", n0); end
    checks++; if (gap0 != 0) begin failures++; $display("FAIL stream_gaps0 got=%0d exp=0", gap0); end
  endtask

  task automatic test_clr();
    drain();
    drive(1'b1, rand_word(), 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, rand_word(), 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, rand_word(), 1'b0, 1'b1, 1'b0);
    checks++; if (s1_occ !== 2'd2) begin failures++; $display("FAIL clr_pre_occ got=%0d exp=2", s1_occ); end
    checks++; if (s1_in_ready !== 1'b0 || s1_out_valid !== 1'b1) begin failures++; $display("FAIL clr_same_cycle got=%0b%0b exp=01", s1_in_ready, s1_out_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (s1_occ !== 2'd0) begin failures++; $display("FAIL clr_occ1 got=%0d exp=0", s1_occ); end
    checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid1 got=%0b exp=0", s1_out_valid); end
    checks++; if (s1_out_data !== BUB1) begin failures++; $display("FAIL clr_data1 got=%0h exp=%0h", s1_out_data, BUB1); end
    checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL clr_inrdy1 got=%0b exp=1", s1_in_ready); end
    checks++; if (s0_occ !== 2'd0 || s0_out_data !== BUB0) begin failures++; $display("FAIL clr_state0 got=%0d/%0h exp=0/%0h", s0_occ, s0_out_data, BUB0); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (s1_out_valid !== 1'b0 || s0_out_valid !== 1'b0) begin failures++; $display("FAIL clr_leak got=%0b%0b exp=00", s1_out_valid, s0_out_valid); end
      tick();
    end
  endtask

  task automatic test_rst_clr();
    drive(1'b1, rand_word(), 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, rand_word(), 1'b0, 1'b0, 1'b0); tick();
    checks++; if (s1_occ !== 2'd2) begin failures++; $display("FAIL rstclr_pre_occ got=%0d exp=2", s1_occ); end
    drive(1'b1, rand_word(), 1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (s1_occ !== 2'd0 || s1_out_valid !== 1'b0) begin failures++; $display("FAIL rstclr_occ1 got=%0d/%0b exp=0/0", s1_occ, s1_out_valid); end
    checks++; if (s1_out_data !== BUB1 || s1_in_ready !== 1'b1) begin failures++; $display("FAIL rstclr_data1 got=%0h/%0b exp=%0h/1", s1_out_data, s1_in_ready, BUB1); end
    checks++; if (s0_in_ready !== 1'b1 || s0_out_data !== BUB0) begin failures++; $display("FAIL rstclr_state0 got=%0b/%0h exp=1/%0h", s0_in_ready, s0_out_data, BUB0); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL rstclr_leak got=%0b exp=0", s1_out_valid); end
      tick();
    end
  endtask

  task automatic test_random();
    logic iv, ordy, c, r;
    for (int i = 0; i < 10000; i++) begin
      iv   = ($urandom_range(3, 0) != 0);
      ordy = ($urandom_range(2, 0) != 0);
      c    = ($urandom_range(99, 0) == 0);
      r    = ($urandom_range(499, 0) == 0);
      drive(iv, rand_word(), ordy, c, r);
      checks++;
      if (s1_out_valid !== (q1.size() > 0) || s1_out_data !== head1() ||
          s1_occ !== 2'(q1.size()) || s1_in_ready !== (q1.size() < 2)) begin
        failures++;
        if (failures < 40) $display("FAIL rand_skid cyc=%0d got=%0b/%0h/%0d/%0b exp=%0b/%0h/%0d/%0b", i,
          s1_out_valid, s1_out_data, s1_occ, s1_in_ready, q1.size() > 0, head1(), q1.size(), q1.size() < 2);
      end
      checks++;
      if (s0_out_valid !== (q0.size() > 0) || s0_out_data !== head0() || s0_occ !== 2'(q0.size())) begin
        failures++;
        if (failures < 40) $display("FAIL rand_single cyc=%0d got=%0b/%0h/%0d exp=%0b/%0h/%0d", i,
          s0_out_valid, s0_out_data, s0_occ, q0.size() > 0, head0(), q0.size());
      end
      checks++;
      if (s0_in_ready !== (!s0_out_valid | ordy) || s0_occ > 2'd1) begin
        failures++;
        if (failures < 40) $display("FAIL rand_single_ready cyc=%0d got=%0b/%0d exp=%0b/<=1", i,
          s0_in_ready, s0_occ, !s0_out_valid | ordy);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_first_word();
    test_skid_fill();
    test_stream();
    test_clr();
    test_rst_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
